uart_rx_controller: RTL and testbench
=====================================

Name: uart_rx_controller

Overview:
- Receive-side sequencer for the UART Rx path.
- Oversamples the serial line, detects and qualifies the start bit, and shifts in 8 data bits LSB-first. It then captures the optional parity bit and the stop bit.
- Presents the frame fields to the parity/frame error checker, strobes its enable (`recieved_flag`), and registers the returned 3-bit error flag together with the data word.
- Sits between the baud/oversample tick generator and the Rx output interface.

Parameters:
- OVERSAMPLE, 16, ticks per bit period; even, ≥4.
- DATA_BITS, 8, data bits per frame; fixed at 8 to match the checker's `raw_data` width.

Ports:
- `clock` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `tick` in 1: oversample strobe, one-`clock` pulse, OVERSAMPLE pulses per bit.
- `rx_in` in 1: asynchronous serial line, idle high.
- `parity_type` in 2: 01 = ODD, 10 = EVEN, 00/11 = no parity bit.
- `error_flag` in 3: {stop, start, parity} returned by the checker.
- `raw_data` out 8: data field to the checker.
- `start_bit` out 1: sampled start bit to the checker.
- `parity_bit` out 1: sampled parity bit to the checker.
- `stop_bit` out 1: sampled stop bit to the checker.
- `parity_sel` out 2: frame-latched parity_type to the checker.
- `recieved_flag` out 1: checker enable, one-cycle pulse.
- `data_out` out 8: registered received word.
- `error_out` out 3: registered {stop, start, parity} flags for `data_out`.
- `data_valid` out 1: one-cycle pulse; `data_out`/`error_out` are valid.
- `busy` out 1: high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE;
  - both synchronizer flops, `stop_bit` and `parity_bit` = 1;
  - `raw_data`, `start_bit`, `parity_sel`, `data_out`, `error_out` = 0;
  - `recieved_flag`, `data_valid`, `busy` = 0;
  - tick counter and bit index = 0;
  - armed = 1.
- `rx_in` passes through a 2-flop synchronizer (`rx_s`). All decisions use `rx_s` and advance only on cycles where `tick` = 1, except CHECK and DONE, which advance every `clock`.
- IDLE:
  - `rx_s` = 1 sets armed.
  - On a tick with armed = 1 and `rx_s` = 0: go to START, counter = 0.
- START:
  - Count ticks; at counter = OVERSAMPLE/2−1 (mid-bit), sample `rx_s`.
  - If `rx_s` = 1: false start; return to IDLE. No fields are updated and no flags are pulsed.
  - Else: `start_bit` = 0, latch `parity_sel` from `parity_type`, counter = 0, bit index = 0, go to DATA.
- DATA:
  - At counter = OVERSAMPLE−1: sample `rx_s` into `raw_data[bit index]`, reset the counter, increment the bit index.
  - After bit 7: go to PARITY if `parity_sel` is 01 or 10, else go to STOP.
- PARITY:
  - At counter = OVERSAMPLE−1: `parity_bit` = `rx_s`.
  - When `parity_sel` is 00/11, `parity_bit` is held at 1 so the checker's default term yields parity flag 0.
- STOP:
  - At counter = OVERSAMPLE−1: `stop_bit` = `rx_s`, then go to CHECK.
  - Clear armed if `rx_s` = 0, so a held-low line (break) cannot retrigger until it returns high.
- CHECK (one `clock`):
  - `recieved_flag` = 1; all frame fields are stable.
  - At the exiting edge: `error_out` ← `error_flag` and `data_out` ← `raw_data`.
  - Go to DONE.
- DONE (one `clock`): `data_valid` = 1, then go to IDLE.
- Latency: `data_valid` asserts exactly 2 `clock` cycles after the tick that samples the stop bit.
- `data_out`/`error_out` hold their value until the next DONE.
- Frame fields stay stable from capture until overwritten by the next frame.
- `parity_type` changes after START have no effect on the current frame.
- `tick` pulses arriving during CHECK/DONE are ignored. They cannot reach START from IDLE until the cycle after DONE.
- Reset asserted mid-frame aborts immediately to the reset values. No `recieved_flag` or `data_valid` is issued for the aborted frame.
- `tick` stuck low: the FSM holds its current state indefinitely.

Test Plan:
- Clean frame, EVEN parity (`parity_type` = 10), OVERSAMPLE = 16, data 0xA5, parity bit 0, stop bit 1:
  - `recieved_flag` pulses once;
  - `data_out` = 0xA5, `error_out` = 000;
  - `data_valid` pulses 2 clocks after the stop-sample tick.
- ODD parity (01), data 0x01, line parity bit 1 (wrong; checker expects 0) → `data_out` = 0x01, `error_out` = 001.
- No parity (00), data 0x3C, stop bit driven 0, line low for 40 ticks afterwards, then high:
  - `error_out` = 100;
  - FSM stays in IDLE and issues no new frame until the line returns high;
  - a following frame with data 0x55 then gives `data_out` = 0x55, `error_out` = 000.
- 4-tick low glitch on an idle line → no START qualified: `busy` returns to 0, and no `recieved_flag` or `data_valid` pulse occurs.
- Reset pulsed during data bit 4 of a 0xFF frame:
  - all outputs return to reset values, with no `data_valid`;
  - a subsequent 0x12 frame is received correctly with `error_out` = 000.
- Back-to-back frames 0x00 then 0xFF with no idle gap beyond the stop bit → two `data_valid` pulses, with `data_out` = 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_rx_controller_if.sv
// Bundle between the Rx sequencer, its tick/line sources, the parity/frame checker
// and the Rx output side.
interface uart_rx_controller_if;
  logic       tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic [2:0] error_flag;
  logic [7:0] raw_data;
  logic       start_bit;
  logic       parity_bit;
  logic       stop_bit;
  logic [1:0] parity_sel;
  logic       recieved_flag;
  logic [7:0] data_out;
  logic [2:0] error_out;
  logic       data_valid;
  logic       busy;

  modport master (
    input  tick, rx_in, parity_type, error_flag,
    output raw_data, start_bit, parity_bit, stop_bit, parity_sel,
           recieved_flag, data_out, error_out, data_valid, busy
  );

  modport slave (
    output tick, rx_in, parity_type, error_flag,
    input  raw_data, start_bit, parity_bit, stop_bit, parity_sel,
           recieved_flag, data_out, error_out, data_valid, busy
  );
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: qualifies the start bit, shifts in data/parity/stop on
// oversample ticks, strobes the external checker and registers word plus error flags.
module uart_rx_controller #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input logic                  clock,
  input logic                  reset,
  uart_rx_controller_if.master bus
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, CHECK, DONE
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic                 armed, armed_n;
  logic [DATA_BITS-1:0] raw_data, raw_n;
  logic                 start_bit, start_n;
  logic                 parity_bit, parity_n;
  logic                 stop_bit, stop_n;
  logic [1:0]           parity_sel, sel_n;
  logic                 rflag, rflag_n;
  logic [DATA_BITS-1:0] data_out, dout_n;
  logic [2:0]           error_out, eout_n;
  logic                 data_valid, dvalid_n;
  logic                 busy, busy_n;
  logic                 par_en;

  // Only 01 (odd) and 10 (even) carry a parity bit on the line
  assign par_en = ^parity_sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      armed      <= 1'b1;
      raw_data   <= '0;
      start_bit  <= 1'b0;
      parity_bit <= 1'b1;
      stop_bit   <= 1'b1;
      parity_sel <= 2'b00;
      rflag      <= 1'b0;
      data_out   <= '0;
      error_out  <= 3'b000;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_meta    <= bus.rx_in;
      rx_s       <= rx_meta;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      armed      <= armed_n;
      raw_data   <= raw_n;
      start_bit  <= start_n;
      parity_bit <= parity_n;
      stop_bit   <= stop_n;
      parity_sel <= sel_n;
      rflag      <= rflag_n;
      data_out   <= dout_n;
      error_out  <= eout_n;
      data_valid <= dvalid_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    armed_n  = armed;
    raw_n    = raw_data;
    start_n  = start_bit;
    parity_n = parity_bit;
    stop_n   = stop_bit;
    sel_n    = parity_sel;
    dout_n   = data_out;
    eout_n   = error_out;
    rflag_n  = 1'b0;
    dvalid_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (rx_s) begin
          armed_n = 1'b1;
        end else if (bus.tick && armed) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: if (bus.tick) begin
        if (cnt == HALF_CNT) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            start_n = 1'b0;
            sel_n   = bus.parity_type;
            // Without a parity bit the checker's default term must see a 1
            if (!(^bus.parity_type)) parity_n = 1'b1;
            cnt_n   = '0;
            idx_n   = '0;
            state_n = DATA;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: if (bus.tick) begin
        if (cnt == LAST_CNT) begin
          raw_n[idx] = rx_s;
          cnt_n      = '0;
          idx_n      = idx + IDX_W'(1);
          if (idx == LAST_IDX) state_n = par_en ? PARITY : STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARITY: if (bus.tick) begin
        if (cnt == LAST_CNT) begin
          parity_n = rx_s;
          cnt_n    = '0;
          state_n  = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: if (bus.tick) begin
        if (cnt == LAST_CNT) begin
          stop_n  = rx_s;
          // A line still low here is a break; wait for it to go high again
          if (!rx_s) armed_n = 1'b0;
          cnt_n   = '0;
          rflag_n = 1'b1;
          state_n = CHECK;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        dout_n   = raw_data;
        eout_n   = bus.error_flag;
        dvalid_n = 1'b1;
        state_n  = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.raw_data      = raw_data;
  assign bus.start_bit     = start_bit;
  assign bus.parity_bit    = parity_bit;
  assign bus.stop_bit      = stop_bit;
  assign bus.parity_sel    = parity_sel;
  assign bus.recieved_flag = rflag;
  assign bus.data_out      = data_out;
  assign bus.error_out     = error_out;
  assign bus.data_valid    = data_valid;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: line-level frame driver, behavioural
// parity/frame checker and a scoreboard of expected {data, error} words.
module tb_uart_rx_controller;

  localparam int unsigned OS        = 16;
  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned BIT_CLKS  = OS * TICK_DIV;

  logic clock;
  logic reset;

  uart_rx_controller_if rx_bus ();

  uart_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rx_bus.master)
  );

  int total = 0;
  int bad   = 0;
  int rf_cnt = 0;
  int dv_cnt = 0;
  bit busy_seen = 1'b0;
  logic prev_rf = 1'b0;
  logic tick_seen = 1'b0;
  logic [10:0] exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural parity/frame checker, enabled by recieved_flag
  logic [2:0] chk_flag;
  always_comb begin
    chk_flag = 3'b000;
    if (rx_bus.recieved_flag) begin
      chk_flag[2] = ~rx_bus.stop_bit;
      chk_flag[1] = rx_bus.start_bit;
      case (rx_bus.parity_sel)
        2'b01:   chk_flag[0] = rx_bus.parity_bit != ~(^rx_bus.raw_data);
        2'b10:   chk_flag[0] = rx_bus.parity_bit != (^rx_bus.raw_data);
        default: chk_flag[0] = ~rx_bus.parity_bit;
      endcase
    end
  end
  assign rx_bus.error_flag = chk_flag;

  // Oversample tick: one clock high every TICK_DIV clocks
  initial begin
    int div = 0;
    rx_bus.tick = 1'b0;
    forever begin
      @(negedge clock);
      rx_bus.tick = (div == int'(TICK_DIV) - 1);
      div = (div + 1) % int'(TICK_DIV);
    end
  end

  always @(posedge clock) tick_seen <= rx_bus.tick;

  // Output monitor and scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_bus.busy) busy_seen = 1'b1;
      if (rx_bus.recieved_flag) begin
        rf_cnt++;
        check("rf_after_tick", 32'(tick_seen), 32'd1);
        check("rf_width", 32'(prev_rf), 32'd0);
      end
      if (rx_bus.data_valid) begin
        logic [10:0] e;
        dv_cnt++;
        check("dv_latency", 32'(prev_rf), 32'd1);
        if (exp_q.size() == 0) begin
          check("dv_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", 32'(rx_bus.data_out), 32'(e[10:3]));
          check("error_out", 32'(rx_bus.error_out), 32'(e[2:0]));
        end
      end
      prev_rf = rx_bus.recieved_flag;
    end else begin
      prev_rf = 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    rx_bus.rx_in = b;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  task automatic idle_clks(input int n);
    rx_bus.rx_in = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Drives one frame and queues its expected word; flip_pt scrambles parity_type after the start bit
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic lp,
                            input logic sv, input bit flip_pt);
    logic       has_par;
    logic [2:0] err;
    has_par = (pt == 2'b01) || (pt == 2'b10);
    err[2] = ~sv;
    err[1] = 1'b0;
    err[0] = has_par ? (lp != ((pt == 2'b01) ? ~(^d) : (^d))) : 1'b0;
    exp_q.push_back({d, err});
    rx_bus.parity_type = pt;
    send_bit(1'b0);
    if (flip_pt) rx_bus.parity_type = 2'b00;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(lp);
    send_bit(sv);
    rx_bus.parity_type = pt;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_raw"},   32'(rx_bus.raw_data), 32'h0);
    check({tag, "_start"}, 32'(rx_bus.start_bit), 32'd0);
    check({tag, "_par"},   32'(rx_bus.parity_bit), 32'd1);
    check({tag, "_stop"},  32'(rx_bus.stop_bit), 32'd1);
    check({tag, "_sel"},   32'(rx_bus.parity_sel), 32'd0);
    check({tag, "_rf"},    32'(rx_bus.recieved_flag), 32'd0);
    check({tag, "_dout"},  32'(rx_bus.data_out), 32'h0);
    check({tag, "_eout"},  32'(rx_bus.error_out), 32'd0);
    check({tag, "_dv"},    32'(rx_bus.data_valid), 32'd0);
    check({tag, "_busy"},  32'(rx_bus.busy), 32'd0);
  endtask

  initial begin
    int rf0;
    int dv0;
    reset = 1'b1;
    rx_bus.rx_in = 1'b1;
    rx_bus.parity_type = 2'b00;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b0;
    idle_clks(40);

    // Odd parity, wrong parity bit on the line
    send_frame(8'h01, 2'b01, 1'b1, 1'b1, 1'b0);
    idle_clks(64);
    check("odd_dv_cnt", 32'(dv_cnt), 32'd1);

    // Even parity, clean; parity_type scrambled mid-frame must not matter
    send_frame(8'hA5, 2'b10, 1'b0, 1'b1, 1'b1);
    idle_clks(64);
    check("even_dv_cnt", 32'(dv_cnt), 32'd2);
    check("even_rf_cnt", 32'(rf_cnt), 32'd2);

    // No parity, stop bit low, then a held break
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0);
    check("brk_par_hold", 32'(rx_bus.parity_bit), 32'd1);
    busy_seen = 1'b0;
    rf0 = rf_cnt;
    rx_bus.rx_in = 1'b0;
    repeat (40 * TICK_DIV) @(negedge clock);
    check("brk_no_busy", 32'(busy_seen), 32'd0);
    check("brk_no_rf", 32'(rf_cnt), 32'(rf0));
    idle_clks(64);
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, 1'b0);
    idle_clks(64);
    check("brk_dv_cnt", 32'(dv_cnt), 32'd4);

    // Short low glitch must not qualify a start bit
    busy_seen = 1'b0;
    rf0 = rf_cnt;
    dv0 = dv_cnt;
    rx_bus.rx_in = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clock);
    idle_clks(80);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy", 32'(rx_bus.busy), 32'd0);
    check("glitch_rf", 32'(rf_cnt), 32'(rf0));
    check("glitch_dv", 32'(dv_cnt), 32'(dv0));

    // Reset during data bit 4 of an 0xFF frame
    dv0 = dv_cnt;
    rx_bus.parity_type = 2'b10;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_bus.rx_in = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle_clks(64);
    check("abort_dv", 32'(dv_cnt), 32'(dv0));
    send_frame(8'h12, 2'b10, 1'b0, 1'b1, 1'b0);
    idle_clks(64);
    check("abort_next_dv", 32'(dv_cnt), 32'(dv0 + 1));

    // Back-to-back frames with no idle gap
    dv0 = dv_cnt;
    send_frame(8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 1'b0);
    idle_clks(64);
    check("b2b_dv", 32'(dv_cnt), 32'(dv0 + 2));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
